// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  // Width of a key code for a rows x cols matrix (never below one bit).
  function automatic int unsigned code_w(input int unsigned rows, input int unsigned cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan prescaler: one-clock tick pulse every SCAN_DIV clocks.
module keypad_tick_gen #(
  parameter int unsigned SCAN_DIV = 500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  // Free-running divider, wraps on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: synchronizer, scan/debounce FSM and event register.
// Optional auto-repeat enabled by defining KEYPAD_SCANNER_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int unsigned ROWS         = 4,
  parameter  int unsigned COLS         = 4,
  parameter  int unsigned SCAN_DIV     = 500000,
  parameter  int unsigned DEBOUNCE     = 3,
  parameter  int unsigned REPEAT_DELAY = 20,
  parameter  int unsigned REPEAT_RATE  = 5,
  localparam int unsigned CODE_W       = code_w(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic              key_lost
);

  localparam int unsigned KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE + 1);

  logic              tick;
  logic [ROWS-1:0]   sync1, row_s;
  state_t            state, state_nxt;
  logic [KW-1:0]     col_k, col_k_nxt;
  logic [DW-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [ROWS-1:0]   pat, pat_nxt;
  logic [CODE_W-1:0] code_q, code_nxt;
  logic              emit, rep_emit, emit_any;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Lowest-index active-low row wins when several rows are down.
  function automatic logic [RW-1:0] low_row(input logic [ROWS-1:0] rows);
    low_row = '0;
    for (int unsigned i = ROWS; i > 0; i--)
      if (!rows[i-1]) low_row = RW'(i - 1);
  endfunction

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      row_s <= '1;
    end else begin
      sync1 <= row_n;
      row_s <= sync1;
    end
  end

  // FSM state and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      col_k  <= '0;
      cnt    <= '0;
      pat    <= '1;
      code_q <= '0;
    end else begin
      state  <= state_nxt;
      col_k  <= col_k_nxt;
      cnt    <= cnt_nxt;
      pat    <= pat_nxt;
      code_q <= code_nxt;
    end
  end

  assign cnt_inc = cnt + DW'(1);

  // Next-state logic; every transition is gated by the scan tick.
  // In HELD, cnt is reused as the consecutive-release counter.
  always_comb begin
    state_nxt = state;
    col_k_nxt = col_k;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    code_nxt  = code_q;
    emit      = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (row_s != '1) begin
            state_nxt = ST_SCAN;
            col_k_nxt = '0;
          end
        end
        ST_SCAN: begin
          if (row_s != '1) begin
            pat_nxt  = row_s;
            code_nxt = CODE_W'(32'(col_k) * ROWS + 32'(low_row(row_s)));
            if (DEBOUNCE <= 1) begin
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
              emit      = 1'b1;
            end else begin
              state_nxt = ST_DEBOUNCE;
              cnt_nxt   = DW'(1);
            end
          end else if (col_k == KW'(COLS - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            col_k_nxt = col_k + KW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (row_s == pat) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DW'(DEBOUNCE)) begin
              state_nxt = ST_HELD;
              cnt_nxt   = '0;
              emit      = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (row_s == '1) begin
            if (cnt_inc == DW'(DEBOUNCE)) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_SCANNER_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned PW   = $clog2(RMAX + 1);

  logic [PW-1:0] rep_cnt, rep_cnt_nxt, rep_inc;
  logic          rep_arm, rep_arm_nxt;

  // Repeat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_arm <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt_nxt;
      rep_arm <= rep_arm_nxt;
    end
  end

  // First repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE;
  // a due slot falling on a released sample is skipped.
  always_comb begin
    rep_cnt_nxt = rep_cnt;
    rep_arm_nxt = rep_arm;
    rep_inc     = rep_cnt + PW'(1);
    rep_emit    = 1'b0;
    if (state != ST_HELD) begin
      rep_cnt_nxt = '0;
      rep_arm_nxt = 1'b0;
    end else if (tick) begin
      if (rep_inc == (rep_arm ? PW'(REPEAT_RATE) : PW'(REPEAT_DELAY))) begin
        rep_cnt_nxt = '0;
        rep_arm_nxt = 1'b1;
        rep_emit    = (row_s != '1);
      end else begin
        rep_cnt_nxt = rep_inc;
      end
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
  assign rep_emit = 1'b0;
`endif

  assign emit_any = emit | rep_emit;

  // Column drive: all columns in IDLE, otherwise only the selected column.
  always_comb begin
    col_n = '0;
    if (state != ST_IDLE) begin
      col_n        = '1;
      col_n[col_k] = 1'b0;
    end
  end

  assign key_held = (state == ST_HELD);

  // Event register: load when free or being drained, otherwise flag a loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_lost  <= 1'b0;
    end else begin
      key_lost <= 1'b0;
      if (emit_any) begin
        if (!key_valid || key_ready) begin
          key_code  <= code_nxt;
          key_valid <= 1'b1;
        end else begin
          key_lost <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (4x4 plus an 8x8 instance).
module tb_keypad_scanner;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int SD = 4;
  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n4, col_n4, key_code4;
  logic        key_valid4, key_ready4, key_held4, key_lost4;
  logic [15:0] pressed4;

  logic [7:0]  row_n8, col_n8;
  logic [5:0]  key_code8;
  logic        key_valid8, key_ready8, key_held8, key_lost8;
  logic [63:0] pressed8;

  int tests = 0;
  int failures = 0;
  int ev_count = 0;
  int lost_seen = 0;
  int exp_q[$];
  longint ev_times[$];
  int exp_tmp;
  int ph = 0;
  logic last_tick = 1'b0;
  int base, lbase;

  always #(PERIOD/2) clk = ~clk;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(2),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_dut (
    .clk(clk), .rst(rst), .row_n(row_n4), .col_n(col_n4),
    .key_code(key_code4), .key_valid(key_valid4), .key_ready(key_ready4),
    .key_held(key_held4), .key_lost(key_lost4)
  );

  keypad_scanner #(
    .ROWS(8), .COLS(8), .SCAN_DIV(SD), .DEBOUNCE(2),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) u_dut8 (
    .clk(clk), .rst(rst), .row_n(row_n8), .col_n(col_n8),
    .key_code(key_code8), .key_valid(key_valid8), .key_ready(key_ready8),
    .key_held(key_held8), .key_lost(key_lost8)
  );

  // Keypad matrix models: a pressed key pulls its row low when its column is driven.
  always_comb begin
    row_n4 = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed4[c*4+r] && !col_n4[c]) row_n4[r] = 1'b0;
  end

  always_comb begin
    row_n8 = '1;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (pressed8[c*8+r] && !col_n8[c]) row_n8[r] = 1'b0;
  end

  // Reference scan-tick phase.
  always @(posedge clk) begin
    last_tick <= !rst && (ph == SD - 1);
    if (rst) ph <= 0;
    else     ph <= (ph == SD - 1) ? 0 : ph + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Handshake monitor: every accepted event is popped from the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_lost4) lost_seen++;
      if (key_valid4 && key_ready4) begin
        ev_count++;
        ev_times.push_back($time);
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_event", 32'(key_code4), 32'hFFFF_FFFF);
        end else begin
          exp_tmp = exp_q.pop_front();
          check_eq("sb_code", 32'(key_code4), 32'(exp_tmp));
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do begin
        @(posedge clk);
        #1;
      end while (!last_tick);
    end
  endtask

  task automatic set_key(input int c, input int r, input logic v);
    pressed4[c*4+r] = v;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    key_ready4 = 1'b1;
    key_ready8 = 1'b0;
    pressed4   = '0;
    pressed8   = '0;
    set_key(0, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_row_n", 32'(row_n4), 32'b1011);
    check_eq("rst_col_n", 32'(col_n4), 0);
    check_eq("rst_valid", 32'(key_valid4), 0);
    check_eq("rst_held", 32'(key_held4), 0);
    check_eq("rst_lost", 32'(key_lost4), 0);
    check_eq("rst_code", 32'(key_code4), 0);
    pressed4 = '0;
    rst = 1'b0;
    base = ev_count;
    wait_ticks(10);
    check_eq("idle_no_event", 32'(ev_count - base), 0);
    check_eq("idle_valid", 32'(key_valid4), 0);

    // Clean press col 2 / row 1.
    base = ev_count;
    set_key(2, 1, 1'b1);
    exp_q.push_back(9);
    wait_ticks(6);
    check_eq("clean_held", 32'(key_held4), 1);
    set_key(2, 1, 1'b0);
    wait_ticks(1);
    check_eq("clean_held_release1", 32'(key_held4), 1);
    wait_ticks(1);
    check_eq("clean_held_release2", 32'(key_held4), 0);
    check_eq("clean_events", 32'(ev_count - base), 1);
    check_eq("clean_sb_drain", 32'(exp_q.size()), 0);

    // Bounce on col 3 / row 0, then stable.
    base = ev_count;
    for (int i = 0; i < 6; i++) begin
      set_key(3, 0, (i % 2 == 0));
      wait_ticks(1);
    end
    check_eq("bounce_quiet", 32'(ev_count - base), 0);
    set_key(3, 0, 1'b1);
    exp_q.push_back(12);
    wait_ticks(8);
    set_key(3, 0, 1'b0);
    wait_ticks(3);
    check_eq("bounce_events", 32'(ev_count - base), 1);
    check_eq("bounce_sb_drain", 32'(exp_q.size()), 0);

    // Two rows low in col 0 on both geometries.
    set_key(0, 1, 1'b1);
    set_key(0, 3, 1'b1);
    pressed8[0*8+1] = 1'b1;
    pressed8[0*8+3] = 1'b1;
    exp_q.push_back(1);
    wait_ticks(5);
    set_key(0, 1, 1'b0);
    set_key(0, 3, 1'b0);
    pressed8 = '0;
    wait_ticks(3);
    check_eq("multi_sb_drain", 32'(exp_q.size()), 0);
    check_eq("multi8_valid", 32'(key_valid8), 1);
    check_eq("multi8_code", 32'(key_code8), 1);
    check_eq("multi8_code_w", 32'($bits(u_dut8.key_code)), 6);

    // Backpressure: second press is lost while the first is pending.
    key_ready4 = 1'b0;
    lbase = lost_seen;
    set_key(1, 1, 1'b1);
    exp_q.push_back(5);
    wait_ticks(6);
    set_key(1, 1, 1'b0);
    wait_ticks(3);
    set_key(1, 2, 1'b1);
    wait_ticks(6);
    check_eq("bp_valid", 32'(key_valid4), 1);
    check_eq("bp_code", 32'(key_code4), 5);
    check_eq("bp_lost", 32'(lost_seen - lbase), 1);
    set_key(1, 2, 1'b0);
    wait_ticks(3);
    key_ready4 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_valid_drop", 32'(key_valid4), 0);
    check_eq("bp_sb_drain", 32'(exp_q.size()), 0);

    // Reset discards a pending event without a loss pulse.
    key_ready4 = 1'b0;
    base = ev_count;
    lbase = lost_seen;
    set_key(2, 1, 1'b1);
    wait_ticks(6);
    check_eq("rstmid_pending", 32'(key_valid4), 1);
    set_key(2, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rstmid_valid", 32'(key_valid4), 0);
    check_eq("rstmid_lost", 32'(key_lost4), 0);
    rst = 1'b0;
    key_ready4 = 1'b1;
    wait_ticks(5);
    check_eq("rstmid_no_event", 32'(ev_count - base), 0);
    check_eq("rstmid_no_lost", 32'(lost_seen - lbase), 0);

    // Long hold: auto-repeat when enabled, a single event otherwise.
    ev_times.delete();
    set_key(2, 1, 1'b1);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(9);
`else
    exp_q.push_back(9);
`endif
    wait_ticks(5);
    wait_ticks(9);
    set_key(2, 1, 1'b0);
    wait_ticks(4);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    check_eq("rep_count", 32'(ev_times.size()), 4);
    begin
      int gaps[3] = '{4, 2, 2};
      for (int i = 1; i < ev_times.size() && i < 4; i++)
        check_eq($sformatf("rep_gap%0d", i),
                 32'((ev_times[i] - ev_times[i-1]) / (SD * PERIOD)), 32'(gaps[i-1]));
    end
`else
    check_eq("hold_single_event", 32'(ev_times.size()), 1);
`endif
    check_eq("hold_sb_drain", 32'(exp_q.size()), 0);
    check_eq("hold_released", 32'(key_held4), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
